// File: rtl/demodulate.sv
// FM quadrature demodulator: conjugate-multiplies each complex sample by the previous one,
// estimates the phase step with a quantized arctangent approximation, and scales it by GAIN.
module demodulate #(
  parameter int DATA_SIZE = 32,
  parameter int BITS      = 10,
  parameter int GAIN      = 758,
  parameter int QUAD1     = 804,
  parameter int QUAD3     = 3 * QUAD1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic signed [DATA_SIZE-1:0] real_in,
  input  logic signed [DATA_SIZE-1:0] imag_in,
  input  logic                        real_empty,
  input  logic                        imag_empty,
  output logic                        real_rd_en,
  output logic                        imag_rd_en,
  output logic signed [DATA_SIZE-1:0] demod_out,
  output logic                        demod_wr_en,
  input  logic                        demod_full
);

  localparam int W  = DATA_SIZE;
  localparam int W2 = 2 * DATA_SIZE;
  localparam int CW = $clog2(DATA_SIZE);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_SIZE - 1);
  localparam logic signed [W-1:0] Q1_C   = W'(QUAD1);
  localparam logic signed [W-1:0] Q3_C   = W'(QUAD3);
  localparam logic signed [W-1:0] GAIN_C = W'(GAIN);

  typedef enum logic [2:0] {
    ST_READ, ST_MULT, ST_SETUP, ST_DIVIDE, ST_ANGLE, ST_GAIN, ST_WRITE
  } state_t;

  // Sign-magnitude shift so negative values round toward zero like positive ones.
  function automatic logic signed [W-1:0] deq(input logic signed [W2-1:0] v);
    logic signed [W2-1:0] m;
    m = v[W2-1] ? -v : v;
    m = m >>> BITS;
    if (v[W2-1]) m = -m;
    return m[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] quant(input logic signed [W-1:0] v);
    return v <<< BITS;
  endfunction

  state_t state, next_state;
  logic rd_fire, wr_fire;

  logic signed [W-1:0] cur_re, cur_im, prev_re, prev_im;
  logic signed [W-1:0] r_val, i_val, base, angle, result;
  logic                y_neg, q_neg;
  logic [W-1:0]        quo, rem, den_mag;
  logic [CW-1:0]       cnt;

  logic signed [W2-1:0] p_rr, p_ii, p_ir, p_ri, p_ang, p_gain;
  logic signed [W-1:0]  mult_r, mult_i, abs_y, num, den, q, ang_raw;
  logic [W-1:0]         num_mag, den_abs, rem_nx, quo_nx;
  logic [W:0]           rem_sh, sub;

  always_comb begin
    next_state = state;
    rd_fire    = 1'b0;
    wr_fire    = 1'b0;
    case (state)
      ST_READ: if (!real_empty && !imag_empty) begin
        rd_fire    = 1'b1;
        next_state = ST_MULT;
      end
      ST_MULT:   next_state = ST_SETUP;
      ST_SETUP:  next_state = ST_DIVIDE;
      ST_DIVIDE: if (cnt == LAST_STEP) next_state = ST_ANGLE;
      ST_ANGLE:  next_state = ST_GAIN;
      ST_GAIN:   next_state = ST_WRITE;
      ST_WRITE: if (!demod_full) begin
        wr_fire    = 1'b1;
        next_state = ST_READ;
      end
      default:   next_state = ST_READ;
    endcase
  end

  // Strobes are gated by reset so they are low for the whole time reset is held.
  assign real_rd_en  = rd_fire & reset;
  assign imag_rd_en  = rd_fire & reset;
  assign demod_wr_en = wr_fire & reset;
  assign demod_out   = demod_wr_en ? result : '0;

  always_comb begin
    p_rr   = W2'(cur_re) * W2'(prev_re);
    p_ii   = W2'(cur_im) * W2'(prev_im);
    p_ir   = W2'(cur_im) * W2'(prev_re);
    p_ri   = W2'(cur_re) * W2'(prev_im);
    mult_r = deq(p_rr) + deq(p_ii);
    mult_i = deq(p_ir) - deq(p_ri);

    abs_y = (i_val[W-1] ? -i_val : i_val) + W'(1);
    if (!r_val[W-1]) begin
      num = quant(r_val - abs_y);
      den = r_val + abs_y;
    end else begin
      num = quant(r_val + abs_y);
      den = abs_y - r_val;
    end
    num_mag = num[W-1] ? -num : num;
    den_abs = den[W-1] ? -den : den;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    rem_sh = {rem, quo[W-1]};
    sub    = rem_sh - {1'b0, den_mag};
    rem_nx = sub[W] ? rem_sh[W-1:0] : sub[W-1:0];
    quo_nx = {quo[W-2:0], ~sub[W]};

    q       = q_neg ? -$signed(quo) : $signed(quo);
    p_ang   = W2'(Q1_C) * W2'(q);
    ang_raw = base - deq(p_ang);
    p_gain  = W2'(GAIN_C) * W2'(angle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_READ;
      cur_re  <= '0;
      cur_im  <= '0;
      prev_re <= '0;
      prev_im <= '0;
      r_val   <= '0;
      i_val   <= '0;
      base    <= '0;
      angle   <= '0;
      result  <= '0;
      y_neg   <= 1'b0;
      q_neg   <= 1'b0;
      quo     <= '0;
      rem     <= '0;
      den_mag <= '0;
      cnt     <= '0;
    end else begin
      state <= next_state;
      case (state)
        ST_READ: if (rd_fire) begin
          cur_re <= real_in;
          cur_im <= imag_in;
        end
        ST_MULT: begin
          r_val   <= mult_r;
          i_val   <= mult_i;
          prev_re <= cur_re;
          prev_im <= cur_im;
        end
        ST_SETUP: begin
          y_neg   <= i_val[W-1];
          base    <= r_val[W-1] ? Q3_C : Q1_C;
          quo     <= num_mag;
          den_mag <= den_abs;
          q_neg   <= num[W-1] ^ den[W-1];
          rem     <= '0;
          cnt     <= '0;
        end
        ST_DIVIDE: begin
          quo <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt + 1'b1;
        end
        ST_ANGLE: angle  <= y_neg ? -ang_raw : ang_raw;
        ST_GAIN:  result <= deq(p_gain);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_demodulate.sv
// Directed and randomized checks of the demodulate block: values, latency, stalls and reset.
module tb_demodulate;

  localparam int W   = 32;
  localparam int LAT = W + 5;

  logic                clock = 1'b0;
  logic                reset;
  logic signed [W-1:0] real_in, imag_in;
  logic                real_empty, imag_empty;
  logic                real_rd_en, imag_rd_en;
  logic signed [W-1:0] demod_out;
  logic                demod_wr_en;
  logic                demod_full;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  demodulate #(
    .DATA_SIZE(W), .BITS(10), .GAIN(758), .QUAD1(804), .QUAD3(2412)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .real_in    (real_in),
    .imag_in    (imag_in),
    .real_empty (real_empty),
    .imag_empty (imag_empty),
    .real_rd_en (real_rd_en),
    .imag_rd_en (imag_rd_en),
    .demod_out  (demod_out),
    .demod_wr_en(demod_wr_en),
    .demod_full (demod_full)
  );

  task automatic chk(input string tag, input logic signed [W-1:0] got, input logic signed [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference arithmetic, using plain wide integers and native truncating division.
  function automatic longint mdeq(input longint v);
    if (v < 0) return -((-v) >>> 10);
    return v >>> 10;
  endfunction

  function automatic int model(input int cr, input int ci, input int pr, input int pi);
    longint r, i, ay, num, den, q, base, ang;
    r  = longint'(int'(mdeq(longint'(cr) * pr) + mdeq(longint'(ci) * pi)));
    i  = longint'(int'(mdeq(longint'(ci) * pr) - mdeq(longint'(cr) * pi)));
    ay = ((i < 0) ? -i : i) + 1;
    if (r >= 0) begin
      num = (r - ay) * 1024; den = r + ay; base = 804;
    end else begin
      num = (r + ay) * 1024; den = ay - r; base = 2412;
    end
    q   = num / den;
    ang = base - mdeq(804 * q);
    if (i < 0) ang = -ang;
    return int'(mdeq(758 * ang));
  endfunction

  task automatic wait_rd(output bit found);
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (real_rd_en && imag_rd_en) begin
        found = 1'b1;
        break;
      end
      @(posedge clock);
    end
  endtask

  // Push one sample, optionally hold the output FIFO full for `stall` cycles at WRITE,
  // then check pop, latency, idle behaviour and the written value.
  task automatic do_sample(input int re, input int im, input int exp, input int stall, input string tag);
    bit found, got_wr, idle_ok;
    int n;
    real_in    = re;
    imag_in    = im;
    real_empty = 1'b0;
    imag_empty = 1'b0;
    demod_full = (stall > 0);
    wait_rd(found);
    chk({tag, " rd"}, found, 1);
    got_wr  = 1'b0;
    idle_ok = 1'b1;
    n       = 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      n = c;
      if (c >= LAT + stall) demod_full = 1'b0;
      #1;
      if (demod_wr_en) begin
        got_wr = 1'b1;
        break;
      end
      if (real_rd_en || imag_rd_en || demod_out !== 0) idle_ok = 1'b0;
    end
    chk({tag, " wr"}, got_wr, 1);
    chk({tag, " latency"}, n, LAT + stall);
    chk({tag, " value"}, demod_out, exp);
    chk({tag, " idle"}, idle_ok, 1);
    tick();
    real_empty = 1'b1;
    imag_empty = 1'b1;
    demod_full = 1'b0;
    #1;
    chk({tag, " wr pulse"}, demod_wr_en, 0);
  endtask

  initial begin : stim
    bit found, quiet;
    int cr, ci, pr, pi, exp;

    // Reset held with both FIFOs non-empty: no strobes may leak out.
    reset      = 1'b0;
    real_in    = 1024;
    imag_in    = 0;
    real_empty = 1'b0;
    imag_empty = 1'b0;
    demod_full = 1'b0;
    #12;
    chk("reset rd_en", real_rd_en | imag_rd_en, 0);
    chk("reset wr_en", demod_wr_en, 0);
    chk("reset out", demod_out, 0);
    real_empty = 1'b1;
    imag_empty = 1'b1;
    tick();
    reset = 1'b1;
    tick();

    do_sample(1024, 0, 1190, 0, "first");
    do_sample(1024, 0, 1, 0, "repeat");
    do_sample(0, 1024, 1190, 0, "quarter");
    do_sample(1024, 0, -1190, 0, "neg_y");
    do_sample(0, 1024, 1190, 10, "stall");

    // Only one FIFO has data: nothing may be popped.
    quiet      = 1'b1;
    real_empty = 1'b0;
    imag_empty = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (real_rd_en || imag_rd_en) quiet = 1'b0;
      tick();
    end
    real_empty = 1'b1;
    imag_empty = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (real_rd_en || imag_rd_en) quiet = 1'b0;
      tick();
    end
    chk("one empty", quiet, 1);

    // Reset in the middle of the divide: sample dropped, history cleared.
    real_in    = 1024;
    imag_in    = 0;
    real_empty = 1'b0;
    imag_empty = 1'b0;
    wait_rd(found);
    chk("abort rd", found, 1);
    tick();
    real_empty = 1'b1;
    imag_empty = 1'b1;
    repeat (10) tick();
    reset = 1'b0;
    #1;
    chk("abort reset outs", {real_rd_en, imag_rd_en, demod_wr_en, (demod_out !== 0)}, 0);
    tick();
    tick();
    reset = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (demod_wr_en || real_rd_en) quiet = 1'b0;
      tick();
    end
    chk("abort no write", quiet, 1);
    do_sample(1024, 0, 1190, 0, "after abort");

    pr = 1024;
    pi = 0;
    for (int k = 0; k < 1000; k++) begin
      cr  = int'($urandom_range(0, 8191)) - 4096;
      ci  = int'($urandom_range(0, 8191)) - 4096;
      exp = model(cr, ci, pr, pi);
      do_sample(cr, ci, exp, (k % 97 == 5) ? 3 : 0, "random");
      pr = cr;
      pi = ci;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
